vending_controller: RTL

Parametrised vending-machine core for the board's coin/button front panel: N products with per-item prices, four debounced coin switches, left/right product browsing, purchase confirm and explicit refund with change output. It sits between the raw panel inputs (switches, push buttons) and the display/LED drivers, which render `credit`, `sel_price`, `avail` and `sel_led`. Adds over the previous machine: any product count, saturating credit, purchase denial, change return and single-event edge detection.

---
 rtl/vending_controller_pkg.sv | 30 +++
 rtl/vending_controller_if.sv | 37 +++
 rtl/vending_controller_edge_pulse.sv | 30 +++
 rtl/vending_controller.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/vending_controller_pkg.sv
// Shared types and defaults for the vending controller: FSM states,
// default price/coin tables and the price lookup helper.
package vending_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    VEND   = 2'd2,
    CHANGE = 2'd3
  } state_t;

  localparam int DEF_NUM_ITEMS = 5;
  localparam int DEF_CREDIT_W  = 7;

  // item0 sits in the low slice: item0=7, item1=5, item2=6, item3=10, item4=8
  localparam logic [DEF_NUM_ITEMS*DEF_CREDIT_W-1:0] DEF_PRICES =
    {7'd8, 7'd10, 7'd6, 7'd5, 7'd7};
  localparam logic [4*DEF_CREDIT_W-1:0] DEF_COIN_VAL =
    {7'd20, 7'd10, 7'd5, 7'd1};

  // Generic over width: caller zero-extends the table and keeps the low credit_w bits.
  function automatic logic [15:0] price_of(input logic [255:0] prices,
                                           input int unsigned credit_w,
                                           input int unsigned idx);
    logic [255:0] sh;
    sh = prices >> (idx * credit_w);
    return sh[15:0] & ((16'd1 << credit_w) - 16'd1);
  endfunction

endpackage

// File: rtl/vending_controller_if.sv
// Front-panel bundle: raw switches/buttons in, credit/selection/pulse outputs back.
interface vending_controller_if #(
  parameter int NUM_ITEMS = 5,
  parameter int CREDIT_W  = 7
);
  localparam int IDX_W = $clog2(NUM_ITEMS);

  logic [3:0]           coin_sw;
  logic                 btn_left;
  logic                 btn_right;
  logic                 btn_confirm;
  logic                 btn_refund;
  logic [CREDIT_W-1:0]  credit;
  logic [IDX_W-1:0]     sel_idx;
  logic [CREDIT_W-1:0]  sel_price;
  logic [NUM_ITEMS-1:0] avail;
  logic [NUM_ITEMS-1:0] sel_led;
  logic                 vend_valid;
  logic [IDX_W-1:0]     vend_item;
  logic                 change_valid;
  logic [CREDIT_W-1:0]  change_amount;
  logic                 deny;
  logic                 coin_reject;

  modport master (
    output coin_sw, btn_left, btn_right, btn_confirm, btn_refund,
    input  credit, sel_idx, sel_price, avail, sel_led, vend_valid, vend_item,
           change_valid, change_amount, deny, coin_reject
  );

  modport slave (
    input  coin_sw, btn_left, btn_right, btn_confirm, btn_refund,
    output credit, sel_idx, sel_price, avail, sel_led, vend_valid, vend_item,
           change_valid, change_amount, deny, coin_reject
  );

endinterface

// File: rtl/vending_controller_edge_pulse.sv
// Two-flop synchroniser plus rising-edge detector; pulse_o is high for one
// cycle per low-to-high transition, history cleared by reset.
module edge_pulse #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] pulse_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] prev_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign pulse_o = sync_q & ~prev_q;

endmodule

// File: rtl/vending_controller.sv
// Vending-machine core: coin credit with saturation, product browsing,
// purchase/deny, refund with change, and a blinking selection LED.
module vending_controller
  import vending_pkg::*;
#(
  parameter int NUM_ITEMS  = DEF_NUM_ITEMS,
  parameter int CREDIT_W   = DEF_CREDIT_W,
  parameter int MAX_CREDIT = 99,
  parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICES   = DEF_PRICES,
  parameter logic [4*CREDIT_W-1:0]         COIN_VAL = DEF_COIN_VAL,
  parameter int BLINK_DIV  = 25_000_000
) (
  input  logic                 clk,
  input  logic                 rst,
  vending_controller_if.slave  bus
);

  localparam int IDX_W   = $clog2(NUM_ITEMS);
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CREDIT_W:0] MAX_C = (CREDIT_W+1)'(MAX_CREDIT);

  state_t               state_q;
  logic [CREDIT_W-1:0]  credit_q;
  logic [IDX_W-1:0]     sel_q;
  logic                 vend_valid_q, change_valid_q, deny_q, coin_reject_q;
  logic [IDX_W-1:0]     vend_item_q;
  logic [CREDIT_W-1:0]  change_amount_q;
  logic [BLINK_W-1:0]   blink_cnt_q;
  logic                 phase_q;

  logic [3:0] coin_pls;
  logic [3:0] btn_pls;

  edge_pulse #(.WIDTH(4)) u_coin_edge (
    .clk     (clk),
    .rst     (rst),
    .d_i     (bus.coin_sw),
    .pulse_o (coin_pls)
  );

  edge_pulse #(.WIDTH(4)) u_btn_edge (
    .clk     (clk),
    .rst     (rst),
    .d_i     ({bus.btn_refund, bus.btn_confirm, bus.btn_right, bus.btn_left}),
    .pulse_o (btn_pls)
  );

  logic                 left_e, right_e, confirm_e, refund_e;
  logic                 coin_any, coin_multi, coin_fits, nav_ok;
  logic [CREDIT_W-1:0]  coin_val;
  logic [CREDIT_W:0]    coin_sum;
  logic [IDX_W-1:0]     nav_d;
  logic [15:0]          price_w;
  logic [CREDIT_W-1:0]  sel_price_c;
  logic [NUM_ITEMS-1:0] avail_c;

  assign {refund_e, confirm_e, right_e, left_e} = btn_pls;

  // Lowest set coin bit wins; any additional bits are rejected together.
  always_comb begin
    coin_val = '0;
    for (int j = 3; j >= 0; j--) begin
      if (coin_pls[j]) coin_val = COIN_VAL[j*CREDIT_W +: CREDIT_W];
    end
  end

  assign coin_any   = |coin_pls;
  assign coin_multi = (coin_pls & (coin_pls - 4'd1)) != 4'd0;
  assign coin_sum   = {1'b0, credit_q} + {1'b0, coin_val};
  assign coin_fits  = coin_sum <= MAX_C;

  assign nav_ok = left_e ^ right_e;
  always_comb begin
    nav_d = sel_q;
    if (right_e) nav_d = (sel_q == IDX_W'(NUM_ITEMS-1)) ? '0 : sel_q + IDX_W'(1);
    else if (left_e) nav_d = (sel_q == '0) ? IDX_W'(NUM_ITEMS-1) : sel_q - IDX_W'(1);
  end

  assign price_w     = price_of(256'(PRICES), CREDIT_W, 32'(sel_q));
  assign sel_price_c = price_w[CREDIT_W-1:0];

  always_comb begin
    avail_c = '0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      avail_c[i] = credit_q >= PRICES[i*CREDIT_W +: CREDIT_W];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q         <= IDLE;
      credit_q        <= '0;
      sel_q           <= '0;
      vend_valid_q    <= 1'b0;
      vend_item_q     <= '0;
      change_valid_q  <= 1'b0;
      change_amount_q <= '0;
      deny_q          <= 1'b0;
      coin_reject_q   <= 1'b0;
      blink_cnt_q     <= '0;
      phase_q         <= 1'b0;
    end else begin
      vend_valid_q   <= 1'b0;
      change_valid_q <= 1'b0;
      deny_q         <= 1'b0;
      coin_reject_q  <= 1'b0;

      if (blink_cnt_q == BLINK_W'(BLINK_DIV-1)) begin
        blink_cnt_q <= '0;
        phase_q     <= ~phase_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + BLINK_W'(1);
      end

      case (state_q)
        IDLE: begin
          if (coin_any) begin
            if (coin_fits) begin
              credit_q <= coin_sum[CREDIT_W-1:0];
              state_q  <= SELECT;
            end
            coin_reject_q <= coin_multi || !coin_fits;
          end else if (nav_ok) begin
            sel_q <= nav_d;
          end
        end
        SELECT: begin
          if (refund_e) begin
            state_q       <= CHANGE;
            coin_reject_q <= coin_any;
          end else if (confirm_e) begin
            coin_reject_q <= coin_any;
            if (credit_q >= sel_price_c) begin
              credit_q <= credit_q - sel_price_c;
              state_q  <= VEND;
            end else begin
              deny_q <= 1'b1;
            end
          end else if (coin_any) begin
            if (coin_fits) credit_q <= coin_sum[CREDIT_W-1:0];
            coin_reject_q <= coin_multi || !coin_fits;
          end else if (nav_ok) begin
            sel_q <= nav_d;
          end
        end
        // Pulses are issued on leaving VEND/CHANGE so a reset in that cycle suppresses them.
        VEND: begin
          vend_valid_q  <= 1'b1;
          vend_item_q   <= sel_q;
          state_q       <= (credit_q != '0) ? SELECT : IDLE;
          coin_reject_q <= coin_any;
        end
        CHANGE: begin
          change_valid_q  <= 1'b1;
          change_amount_q <= credit_q;
          credit_q        <= '0;
          state_q         <= IDLE;
          coin_reject_q   <= coin_any;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.credit        = credit_q;
  assign bus.sel_idx       = sel_q;
  assign bus.sel_price     = sel_price_c;
  assign bus.avail         = avail_c;
  assign bus.sel_led       = (state_q == SELECT && phase_q) ? (NUM_ITEMS'(1) << sel_q) : '0;
  assign bus.vend_valid    = vend_valid_q;
  assign bus.vend_item     = vend_item_q;
  assign bus.change_valid  = change_valid_q;
  assign bus.change_amount = change_amount_q;
  assign bus.deny          = deny_q;
  assign bus.coin_reject   = coin_reject_q;

endmodule
